pll_rst_sequencer: RTL and testbench

- Reset/lock sequencer wrapped around the core PLL. Drives the PLL `rst` input and consumes its `locked` output.
- Runs on the free-running 50 MHz board clock.
- Holds the RISC-V core in reset until the PLL has been locked continuously for a qualification window.
- Re-pulses the PLL reset if lock is not acquired within a timeout. Re-asserts core reset immediately on lock loss.

---
 rtl/pll_rst_sequencer.sv | 135 +++++++++++++
 tb/tb_pll_rst_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_sequencer.sv
// Purpose: PLL reset/lock sequencer; holds core reset until PLL lock is qualified, retries PLL reset on timeout.
// Latency: locked_i change to core_rst/ready change is SYNC_STAGES+1 edges (+LOCK_STABLE_CYCLES on release); outputs registered.
// Backpressure: none; free-running. Optional status counters enabled by `define PLL_RST_SEQ_STATUS_EN.
module pll_rst_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_i,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt
);

  localparam int MAX_A  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P  = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] PLL_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;
  logic                   timeout_err_nxt;

  assign lk = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous lock flag into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
  end

  // State, shared counter and registered outputs, all loaded from next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      core_rst    <= 1'b1;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pll_rst     <= (state_nxt == S_PLL_RST);
      core_rst    <= (state_nxt != S_RUN);
      ready       <= (state_nxt == S_RUN);
      timeout_err <= timeout_err_nxt;
    end
  end

  // Next-state logic; the counter restarts from zero on every transition.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + 1'b1;
    timeout_err_nxt = timeout_err;
    case (state)
      S_PLL_RST: begin
        if (cnt == PLL_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt       = S_PLL_RST;
          cnt_nxt         = '0;
          timeout_err_nxt = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (!lk) state_nxt = S_WAIT_LOCK;
      end
      default: begin
        state_nxt = S_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PLL_RST_SEQ_STATUS_EN
  logic retry_inc;
  logic loss_inc;

  assign retry_inc = (state == S_WAIT_LOCK) && !lk && (cnt == TIMEOUT_LAST);
  assign loss_inc  = (state == S_RUN) && !lk;

  // Saturating event counters, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt     <= 8'h00;
      lock_loss_cnt <= 8'h00;
    end else begin
      if (retry_inc && (retry_cnt != 8'hFF))
        retry_cnt <= retry_cnt + 8'd1;
      if (loss_inc && (lock_loss_cnt != 8'hFF))
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`else
  assign retry_cnt     = 8'h00;
  assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Bench for pll_rst_sequencer: directed lock/timeout/glitch/reset scenarios followed by random lock traffic,
// every cycle compared against a timestamp-based reference model.
// Works in both builds of PLL_RST_SEQ_STATUS_EN.
module tb_pll_rst_sequencer;

  localparam int SS = 2;
  localparam int PR = 4;
  localparam int LS = 8;
  localparam int LT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked_i;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       timeout_err;
  logic [7:0] lock_loss_cnt;
  logic [7:0] retry_cnt;

  always #5 clk = ~clk;

  pll_rst_sequencer #(
    .SYNC_STAGES(SS),
    .PLL_RST_CYCLES(PR),
    .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT_CYCLES(LT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked_i(locked_i),
    .pll_rst(pll_rst),
    .core_rst(core_rst),
    .ready(ready),
    .timeout_err(timeout_err),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt(retry_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a phase label plus the edge number at which the phase began.
  // Phase ends are found by comparing the current edge against start + duration.
  localparam int PH_PLL = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RUN = 3;
  int cyc      = 0;
  int m_phase  = PH_PLL;
  int m_start  = 0;
  bit m_terr   = 0;
  int m_loss   = 0;
  int m_retry  = 0;
  bit m_hist[$];   // last SS samples of locked_i, newest first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l);
    bit lkv;
    cyc++;
    if (r) begin
      m_hist = {};
      repeat (SS) m_hist.push_back(1'b0);
      m_phase = PH_PLL;
      m_start = cyc;
      m_terr  = 0;
      m_loss  = 0;
      m_retry = 0;
      return;
    end
    lkv = m_hist[SS-1];
    m_hist.push_front(l);
    void'(m_hist.pop_back());
    case (m_phase)
      PH_PLL:  if (cyc == m_start + PR) begin m_phase = PH_WAIT; m_start = cyc; end
      PH_WAIT: begin
        if (lkv) begin
          m_phase = PH_QUAL; m_start = cyc;
        end else if (cyc == m_start + LT) begin
          m_phase = PH_PLL; m_start = cyc; m_terr = 1;
          if (m_retry < 255) m_retry++;
        end
      end
      PH_QUAL: begin
        if (!lkv) begin m_phase = PH_WAIT; m_start = cyc; end
        else if (cyc == m_start + LS) m_phase = PH_RUN;
      end
      default: begin
        if (!lkv) begin
          m_phase = PH_WAIT; m_start = cyc;
          if (m_loss < 255) m_loss++;
        end
      end
    endcase
  endtask

  // One clock: drive inputs, let the edge happen, then compare every output on the falling edge.
  task automatic tick(input bit r, input bit l);
    int exp_loss, exp_retry;
    rst      = r;
    locked_i = l;
    @(posedge clk);
    model_edge(r, l);
    @(negedge clk);
`ifdef PLL_RST_SEQ_STATUS_EN
    exp_loss  = m_loss;
    exp_retry = m_retry;
`else
    exp_loss  = 0;
    exp_retry = 0;
`endif
    chk("pll_rst",       32'(pll_rst),       32'(m_phase == PH_PLL));
    chk("core_rst",      32'(core_rst),      32'(m_phase != PH_RUN));
    chk("ready",         32'(ready),         32'(m_phase == PH_RUN));
    chk("timeout_err",   32'(timeout_err),   32'(m_terr));
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss));
    chk("retry_cnt",     32'(retry_cnt),     32'(exp_retry));
  endtask

  initial begin
    int lat;
    int hi_cnt;
    bit cur;
    int hold;

    rst      = 1'b1;
    locked_i = 1'b0;

    // Reset state.
    repeat (3) tick(1, 0);

    // Reset release with no lock: pll_rst drops on the 4th edge after rst goes low.
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0);
      if (i == 3) chk("pll_rst_still_high", 32'(pll_rst), 32'd1);
      if (i == 4) chk("pll_rst_dropped",    32'(pll_rst), 32'd0);
    end
    repeat (3) tick(0, 0);

    // Lock acquired and held: release 11 edges after the change.
    lat = 0;
    do begin tick(0, 1); lat++; end while (ready !== 1'b1 && lat < 40);
    chk("lock_latency", 32'(lat), 32'd11);
    chk("pll_rst_in_run", 32'(pll_rst), 32'd0);
    repeat (4) tick(0, 1);

    // Lock loss in run: core_rst back within 3 edges, then re-lock.
    lat = 0;
    do begin tick(0, 0); lat++; end while (core_rst !== 1'b1 && lat < 40);
    chk("loss_latency", 32'(lat), 32'd3);
    chk("pll_rst_no_pulse_on_loss", 32'(pll_rst), 32'd0);
    tick(0, 0);
    lat = 0;
    do begin tick(0, 1); lat++; end while (ready !== 1'b1 && lat < 40);
    chk("relock_latency", 32'(lat), 32'd11);

    // Drop lock, then a one-cycle lock glitch during qualification.
    repeat (6) tick(0, 0);
    repeat (5) tick(0, 1);
    tick(0, 0);
    lat = 0;
    do begin tick(0, 1); lat++; end while (ready !== 1'b1 && lat < 40);
    chk("glitch_latency", 32'(lat), 32'd11);
    chk("no_timeout_yet", 32'(timeout_err), 32'd0);

    // Lock never returns: exactly one 4-cycle pll_rst retry pulse within 45 cycles.
    hi_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      tick(0, 0);
      if (pll_rst === 1'b1) hi_cnt++;
    end
    chk("retry_pulse_width", 32'(hi_cnt), 32'd4);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset mid-qualification: everything back to reset values on the next edge.
    repeat (30) tick(0, 0);
    repeat (5) tick(0, 1);
    tick(1, 1);
    chk("rst_pll_rst",     32'(pll_rst),     32'd1);
    chk("rst_core_rst",    32'(core_rst),    32'd1);
    chk("rst_ready",       32'(ready),       32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_retry_cnt",   32'(retry_cnt),   32'd0);
    // Lock already high during the pll reset phase: still a full 4-cycle pulse.
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1);
      if (pll_rst === 1'b1) hi_cnt++;
    end
    chk("restart_pll_width", 32'(hi_cnt), 32'd3);

    // Random lock traffic with long and short runs and occasional resets.
    cur = 1'b0;
    for (int i = 0; i < 3000; i += hold) begin
      hold = (($urandom % 4) == 0) ? int'($urandom_range(20, 50)) : int'($urandom_range(1, 12));
      cur  = ~cur;
      for (int j = 0; j < hold; j++)
        tick((($urandom % 400) == 0) ? 1'b1 : 1'b0, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
